// File: rtl/sbox_arbiter.sv
// sbox_arbiter: shares one 128-bit combinational sub_bytes array between the
// cipher round datapath (full SubBytes) and the key-expansion unit (SubWord).
// Requests use valid/ready; each response is held until its owner takes it.
// Optional build macro SBOX_ARB_FIXED_PRI_EN: the key requester always wins
// a tie and no round-robin pointer exists. Undefined: round-robin arbitration.

// sub_bytes: 16 parallel AES S-boxes, S(x) = affine(x^-1) over GF(2^8).
module sub_bytes (
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse for a != 0 and yields 0 for a == 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Substitute every byte of the 128-bit word independently
  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      data_out[8*i +: 8] = sbox(data_in[8*i +: 8]);
    end
  end

endmodule

module sbox_arbiter #(
  parameter int unsigned KEY_LANE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rnd_req_valid,
  output logic         rnd_req_ready,
  input  logic [127:0] rnd_req_data,
  output logic         rnd_rsp_valid,
  input  logic         rnd_rsp_ready,
  output logic [127:0] rnd_rsp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_data,
  output logic         key_rsp_valid,
  input  logic         key_rsp_ready,
  output logic [31:0]  key_rsp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic {
    OWN_RND = 1'b0,
    OWN_KEY = 1'b1
  } owner_t;

  state_t       state_q;
  state_t       state_d;
  owner_t       owner_q;
`ifndef SBOX_ARB_FIXED_PRI_EN
  owner_t       ptr_q;
`endif
  logic [127:0] sb_in_q;
  logic [127:0] sb_out;
  logic [127:0] key_in_wide;
  logic [127:0] rnd_rsp_data_q;
  logic [31:0]  key_rsp_data_q;
  logic         grant_rnd;
  logic         grant_key;
  logic         accept;
  logic         owner_ready;

  sub_bytes u_sub_bytes (
    .data_in  (sb_in_q),
    .data_out (sb_out)
  );

  // Grant logic: only in IDLE, and suppressed while reset is asserted so the
  // ready outputs are low for the whole reset window
  always_comb begin
    grant_rnd = 1'b0;
    grant_key = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (rnd_req_valid && key_req_valid) begin
`ifdef SBOX_ARB_FIXED_PRI_EN
        grant_key = 1'b1;
`else
        if (ptr_q == OWN_RND) grant_rnd = 1'b1;
        else                  grant_key = 1'b1;
`endif
      end else begin
        grant_rnd = rnd_req_valid;
        grant_key = key_req_valid;
      end
    end
  end

  assign accept        = grant_rnd | grant_key;
  assign rnd_req_ready = grant_rnd;
  assign key_req_ready = grant_key;

  // Place the key word in its lane of the shared array, other lanes zero
  always_comb begin
    key_in_wide = '0;
    key_in_wide[32*KEY_LANE +: 32] = key_req_data;
  end

  assign owner_ready = (owner_q == OWN_RND) ? rnd_rsp_ready : key_rsp_ready;

  // Next-state: accept -> EVAL -> HOLD until the owner consumes its result
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    state_d = HOLD;
      HOLD:    if (owner_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Accept edge: capture request data, record owner, hand priority over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_in_q <= '0;
      owner_q <= OWN_RND;
`ifndef SBOX_ARB_FIXED_PRI_EN
      ptr_q   <= OWN_RND;
`endif
    end else if (accept) begin
      if (grant_key) begin
        sb_in_q <= key_in_wide;
        owner_q <= OWN_KEY;
`ifndef SBOX_ARB_FIXED_PRI_EN
        ptr_q   <= OWN_RND;
`endif
      end else begin
        sb_in_q <= rnd_req_data;
        owner_q <= OWN_RND;
`ifndef SBOX_ARB_FIXED_PRI_EN
        ptr_q   <= OWN_KEY;
`endif
      end
    end
  end

  // EVAL: capture the S-box result into the owner's result register only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_rsp_data_q <= '0;
      key_rsp_data_q <= '0;
    end else if (state_q == EVAL) begin
      if (owner_q == OWN_KEY) key_rsp_data_q <= sb_out[32*KEY_LANE +: 32];
      else                    rnd_rsp_data_q <= sb_out;
    end
  end

  assign rnd_rsp_valid = (state_q == HOLD) && (owner_q == OWN_RND);
  assign key_rsp_valid = (state_q == HOLD) && (owner_q == OWN_KEY);
  assign rnd_rsp_data  = rnd_rsp_data_q;
  assign key_rsp_data  = key_rsp_data_q;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Self-checking bench for sbox_arbiter: two instances (KEY_LANE 0 and 3)
// share stimulus; a scoreboard queues the expected results at each accept
// and compares them when the owner takes its response.
module tb_sbox_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rnd_req_valid;
  logic         rnd_req_ready;
  logic [127:0] rnd_req_data;
  logic         rnd_rsp_valid;
  logic         rnd_rsp_ready;
  logic [127:0] rnd_rsp_data;
  logic         key_req_valid;
  logic         key_req_ready;
  logic [31:0]  key_req_data;
  logic         key_rsp_valid;
  logic         key_rsp_ready;
  logic [31:0]  key_rsp_data;

  logic         rnd_req_ready_l3;
  logic         rnd_rsp_valid_l3;
  logic [127:0] rnd_rsp_data_l3;
  logic         key_req_ready_l3;
  logic         key_rsp_valid_l3;
  logic [31:0]  key_rsp_data_l3;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [7:0]   sbox_tbl [256];
  logic [127:0] rnd_exp_q [$];
  logic [31:0]  key_exp_q [$];
  logic         grant_log [$];
  logic [127:0] rnd_e;
  logic [31:0]  key_e;

  always #5 clk = ~clk;

  sbox_arbiter #(.KEY_LANE(0)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rnd_req_valid (rnd_req_valid),
    .rnd_req_ready (rnd_req_ready),
    .rnd_req_data  (rnd_req_data),
    .rnd_rsp_valid (rnd_rsp_valid),
    .rnd_rsp_ready (rnd_rsp_ready),
    .rnd_rsp_data  (rnd_rsp_data),
    .key_req_valid (key_req_valid),
    .key_req_ready (key_req_ready),
    .key_req_data  (key_req_data),
    .key_rsp_valid (key_rsp_valid),
    .key_rsp_ready (key_rsp_ready),
    .key_rsp_data  (key_rsp_data)
  );

  sbox_arbiter #(.KEY_LANE(3)) u_dut_l3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .rnd_req_valid (rnd_req_valid),
    .rnd_req_ready (rnd_req_ready_l3),
    .rnd_req_data  (rnd_req_data),
    .rnd_rsp_valid (rnd_rsp_valid_l3),
    .rnd_rsp_ready (rnd_rsp_ready),
    .rnd_rsp_data  (rnd_rsp_data_l3),
    .key_req_valid (key_req_valid),
    .key_req_ready (key_req_ready_l3),
    .key_req_data  (key_req_data),
    .key_rsp_valid (key_rsp_valid_l3),
    .key_rsp_ready (key_rsp_ready),
    .key_rsp_data  (key_rsp_data_l3)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // S-box table built with the generator walk (p over GF(2^8)*, q = p^-1)
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tbl[p] = x ^ 8'h63;
    end
    sbox_tbl[0] = 8'h63;
  endtask

  function automatic logic [127:0] model_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tbl[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] model_sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_tbl[w[8*i +: 8]];
    return r;
  endfunction

  // Scoreboard monitor: sampled mid-cycle, inputs only change just after posedge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rnd_req_valid && rnd_req_ready) begin
        rnd_exp_q.push_back(model_sub_bytes(rnd_req_data));
        grant_log.push_back(1'b0);
      end
      if (key_req_valid && key_req_ready) begin
        key_exp_q.push_back(model_sub_word(key_req_data));
        grant_log.push_back(1'b1);
      end
      if (rnd_rsp_valid && rnd_rsp_ready) begin
        if (rnd_exp_q.size() == 0) begin
          check("rnd_unexpected_rsp", rnd_rsp_valid, 1'b0);
        end else begin
          rnd_e = rnd_exp_q.pop_front();
          check("rnd_rsp_data", rnd_rsp_data, rnd_e);
          check("rnd_rsp_data_l3", rnd_rsp_data_l3, rnd_e);
        end
      end
      if (key_rsp_valid && key_rsp_ready) begin
        if (key_exp_q.size() == 0) begin
          check("key_unexpected_rsp", key_rsp_valid, 1'b0);
        end else begin
          key_e = key_exp_q.pop_front();
          check("key_rsp_data", key_rsp_data, key_e);
          check("key_rsp_data_l3", key_rsp_data_l3, key_e);
        end
      end
    end
  end

  task automatic send_rnd(input logic [127:0] d);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    rnd_req_valid = 1'b1;
    rnd_req_data  = d;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rnd_req_ready) begin got = 1'b1; break; end
    end
    check("rnd_accept_timeout", got, 1'b1);
    @(posedge clk); #1;
    rnd_req_valid = 1'b0;
    rnd_req_data  = ~d;
  endtask

  task automatic send_key(input logic [31:0] d);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    key_req_valid = 1'b1;
    key_req_data  = d;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (key_req_ready) begin got = 1'b1; break; end
    end
    check("key_accept_timeout", got, 1'b1);
    @(posedge clk); #1;
    key_req_valid = 1'b0;
    key_req_data  = ~d;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rnd_exp_q.size() == 0 && key_exp_q.size() == 0 && !rnd_rsp_valid && !key_rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   exp_order;
    logic [127:0] bp_exp;
    bit           got;

    build_sbox();
    rst_n         = 1'b0;
    rnd_req_valid = 1'b0;
    rnd_req_data  = '0;
    key_req_valid = 1'b0;
    key_req_data  = '0;
    rnd_rsp_ready = 1'b1;
    key_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctl", {rnd_req_ready, key_req_ready, rnd_rsp_valid, key_rsp_valid}, 4'b0000);
    check("rst_rnd_data", rnd_rsp_data, '0);
    check("rst_key_data", key_rsp_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both requesters valid straight after reset
`ifdef SBOX_ARB_FIXED_PRI_EN
    exp_order = 4'b1111;
`else
    exp_order = 4'b1010;
`endif
    grant_log.delete();
    rnd_req_valid = 1'b1;
    rnd_req_data  = 128'h00102030405060708090a0b0c0d0e0f0;
    key_req_valid = 1'b1;
    key_req_data  = 32'h09cf4f3c;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 4) begin got = 1'b1; break; end
    end
    check("tie_grant_timeout", got, 1'b1);
    @(posedge clk); #1;
    key_req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 5) begin got = 1'b1; break; end
    end
    check("tie_last_timeout", got, 1'b1);
    @(posedge clk); #1;
    rnd_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > i) check($sformatf("grant_order_%0d", i), grant_log[i], exp_order[i]);
    end
    if (grant_log.size() > 4) check("grant_order_4", grant_log[4], 1'b0);
    wait_drain();

    // Round only: latency, known vector, data change after accept
    send_rnd(128'h00102030405060708090a0b0c0d0e0f0);
    @(negedge clk);
    check("rnd_lat_eval", {rnd_rsp_valid, rnd_req_ready, key_req_ready}, 3'b000);
    @(negedge clk);
    check("rnd_lat_hold", rnd_rsp_valid, 1'b1);
    check("rnd_key_quiet", key_rsp_valid, 1'b0);
    check("rnd_vector", rnd_rsp_data, 128'h63cab7040953d051cd60e0e7ba70e18c);
    wait_drain();

    // Key only: both lane configurations give the same word
    send_key(32'h09cf4f3c);
    @(negedge clk);
    check("key_lat_eval", key_rsp_valid, 1'b0);
    @(negedge clk);
    check("key_lat_hold", key_rsp_valid, 1'b1);
    check("key_rnd_quiet", rnd_rsp_valid, 1'b0);
    check("key_vector_l0", key_rsp_data, 32'h018a84eb);
    check("key_vector_l3", key_rsp_data_l3, 32'h018a84eb);
    wait_drain();

    // Backpressure on the round response with a key request waiting
    rnd_rsp_ready = 1'b0;
    bp_exp = model_sub_bytes(128'hdeadbeef_01234567_89abcdef_f0e1d2c3);
    send_rnd(128'hdeadbeef_01234567_89abcdef_f0e1d2c3);
    @(negedge clk);
    @(posedge clk); #1;
    key_req_valid = 1'b1;
    key_req_data  = 32'h53a1c0de;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", rnd_rsp_valid, 1'b1);
      check("bp_data", rnd_rsp_data, bp_exp);
      check("bp_req_ready", {rnd_req_ready, key_req_ready}, 2'b00);
    end
    @(posedge clk); #1;
    rnd_rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_back_idle", key_req_ready, 1'b1);
    @(posedge clk); #1;
    key_req_valid = 1'b0;
    wait_drain();
    check("bp_data_held", rnd_rsp_data, bp_exp);

    // Random single transactions
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1) == 1) send_rnd({$urandom, $urandom, $urandom, $urandom});
      else                        send_key($urandom);
      wait_drain();
    end

    // Reset asserted during EVAL drops the transaction
    send_rnd(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    key_req_valid = 1'b1;
    key_req_data  = 32'h11223344;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {rnd_req_ready, key_req_ready, rnd_rsp_valid, key_rsp_valid}, 4'b0000);
    check("mid_rst_rnd_data", rnd_rsp_data, '0);
    check("mid_rst_key_data", key_rsp_data, '0);
    key_req_valid = 1'b0;
    rnd_exp_q.delete();
    key_exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {rnd_rsp_valid, key_rsp_valid}, 2'b00);
    end
    check("post_rst_data", rnd_rsp_data, '0);

    // Reissue after reset completes normally
    send_rnd(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    wait_drain();
    check("reissue_rnd", rnd_rsp_data, model_sub_bytes(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0));
    send_key(32'h11223344);
    wait_drain();
    check("reissue_key", key_rsp_data, {24'h0, sbox_tbl[8'h11]} << 24 | {24'h0, sbox_tbl[8'h22]} << 16
                                     | {24'h0, sbox_tbl[8'h33]} << 8 | {24'h0, sbox_tbl[8'h44]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
